// File: rtl/level_generator_if.sv
// ============================================================================
// Module      : level_generator_if
// Description : Request/status bundle between a count source and the level
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface level_generator_if #(
  parameter int count_max = 8
);
  logic                 start;
  logic [count_max-1:0] hold_count;
  logic                 lv_out;
  logic                 busy;
  logic                 done;
  logic [count_max-1:0] remaining;

  modport master (
    output start,
    output hold_count,
    input  lv_out,
    input  busy,
    input  done,
    input  remaining
  );

  modport slave (
    input  start,
    input  hold_count,
    output lv_out,
    output busy,
    output done,
    output remaining
  );
endinterface

`default_nettype wire

// File: rtl/level_generator.sv
// ============================================================================
// Module      : level_generator
// Description : Drives lv_out high for hold_count slow ticks, using its own
//               free-running tick divider. Optional macro
//               LEVEL_GEN_RETRIGGER_EN lets start reload the count while busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_generator #(
  parameter int count_max = 8,
  parameter int TICK_DIV  = 50_000_000
) (
  input  wire logic          CLK100MHZ,
  input  wire logic          reset,
  level_generator_if.slave   bus
);

  localparam int                c_TW        = $clog2(TICK_DIV);
  localparam logic [c_TW-1:0]   c_TICK_LAST = c_TW'(TICK_DIV - 1);
  localparam logic [1:0]        c_ST_IDLE   = 2'd0;
  localparam logic [1:0]        c_ST_ARM    = 2'd1;
  localparam logic [1:0]        c_ST_DRIVE  = 2'd2;

  logic [c_TW-1:0]      r_tick_cnt;
  logic [1:0]           r_state;
  logic                 r_lv;
  logic                 r_done;
  logic [count_max-1:0] r_remaining;

  logic w_tick;
  logic w_hold_zero;
  logic w_retrig;
  logic w_arm_cancel;

  assign w_tick      = (r_tick_cnt == c_TICK_LAST);
  assign w_hold_zero = (bus.hold_count == '0);

`ifdef LEVEL_GEN_RETRIGGER_EN
  assign w_retrig = bus.start;
`else
  assign w_retrig = 1'b0;
`endif

  // A zero reload while armed cancels the request at the next tick.
  assign w_arm_cancel = w_retrig ? w_hold_zero : (r_remaining == '0);

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TW'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_IDLE;
      r_lv        <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          // A tick coinciding with acceptance is deliberately not consumed.
          if (bus.start) begin
            if (!w_hold_zero) begin
              r_remaining <= bus.hold_count;
              r_state     <= c_ST_ARM;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        c_ST_ARM: begin
          if (w_retrig) begin
            r_remaining <= bus.hold_count;
          end
          if (w_tick) begin
            if (w_arm_cancel) begin
              r_state     <= c_ST_IDLE;
              r_done      <= 1'b1;
              r_remaining <= '0;
            end else begin
              r_state <= c_ST_DRIVE;
              r_lv    <= 1'b1;
            end
          end
        end
        c_ST_DRIVE: begin
          if (w_retrig && !w_hold_zero) begin
            r_remaining <= bus.hold_count;
          end else if (w_tick) begin
            if (w_retrig || (r_remaining <= count_max'(1))) begin
              r_state     <= c_ST_IDLE;
              r_lv        <= 1'b0;
              r_done      <= 1'b1;
              r_remaining <= '0;
            end else begin
              r_remaining <= r_remaining - count_max'(1);
            end
          end else if (w_retrig) begin
            r_remaining <= count_max'(1);
          end
        end
        default: begin
          r_state     <= c_ST_IDLE;
          r_lv        <= 1'b0;
          r_remaining <= '0;
        end
      endcase
    end
  end

  assign bus.lv_out    = r_lv;
  assign bus.busy      = (r_state != c_ST_IDLE);
  assign bus.done      = r_done;
  assign bus.remaining = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_level_generator.sv
// ============================================================================
// Module      : tb_level_generator
// Description : Directed cycle-accurate checks of level_generator, TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_level_generator;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  level_generator_if #(.count_max(8)) bus ();

  level_generator #(
    .count_max (8),
    .TICK_DIV  (4)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic drive(input logic s, input logic [7:0] h);
    bus.start      = s;
    bus.hold_count = h;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    drive(1'b0, 8'd0);

    #12;
    check("rst_lv",   bus.lv_out,    0);
    check("rst_busy", bus.busy,      0);
    check("rst_done", bus.done,      0);
    check("rst_rem",  bus.remaining, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;

    // Basic hold_count=3: lv high from edge 4 to edge 16.
    go_to(1);  drive(1'b1, 8'd3);
    go_to(2);  drive(1'b0, 8'd0);
    check("t1_busy", bus.busy, 1);
    check("t1_rem_arm", bus.remaining, 3);
    check("t1_lv_arm", bus.lv_out, 0);
    go_to(3);  check("t1_lv_pre", bus.lv_out, 0);
    go_to(4);  check("t1_lv_rise", bus.lv_out, 1);
               check("t1_rem4", bus.remaining, 3);
    go_to(7);  check("t1_rem7", bus.remaining, 3);
    go_to(8);  check("t1_rem8", bus.remaining, 2);
    go_to(12); check("t1_rem12", bus.remaining, 1);
    go_to(15); check("t1_lv15", bus.lv_out, 1);
               check("t1_done15", bus.done, 0);
    go_to(16); check("t1_lv_fall", bus.lv_out, 0);
               check("t1_done", bus.done, 1);
               check("t1_rem_end", bus.remaining, 0);
               check("t1_busy_end", bus.busy, 0);
    // New start in the done cycle.
    drive(1'b1, 8'd2);
    go_to(17); drive(1'b0, 8'd0);
    check("t2_done_clr", bus.done, 0);
    check("t2_busy", bus.busy, 1);
    check("t2_rem", bus.remaining, 2);
    go_to(19); check("t2_lv19", bus.lv_out, 0);
    go_to(20); check("t2_lv20", bus.lv_out, 1);
    go_to(27); check("t2_lv27", bus.lv_out, 1);
    go_to(28); check("t2_lv28", bus.lv_out, 0);
               check("t2_done", bus.done, 1);

    // Start coincident with a tick in IDLE: that tick is not consumed.
    go_to(31); drive(1'b1, 8'd1);
    go_to(32); drive(1'b0, 8'd0);
    check("t3_busy", bus.busy, 1);
    check("t3_lv32", bus.lv_out, 0);
    check("t3_rem", bus.remaining, 1);
    go_to(35); check("t3_lv35", bus.lv_out, 0);
    go_to(36); check("t3_lv36", bus.lv_out, 1);
    go_to(39); check("t3_lv39", bus.lv_out, 1);
    go_to(40); check("t3_lv40", bus.lv_out, 0);
               check("t3_done", bus.done, 1);

    // hold_count = 0.
    drive(1'b1, 8'd0);
    go_to(41); drive(1'b0, 8'd0);
    check("t4_done", bus.done, 1);
    check("t4_busy", bus.busy, 0);
    check("t4_lv", bus.lv_out, 0);
    go_to(42); check("t4_done_clr", bus.done, 0);

    // Full-scale 255 ticks: lv high edges 44..1064.
    drive(1'b1, 8'd255);
    go_to(43); drive(1'b0, 8'd0);
    check("t5_rem_arm", bus.remaining, 255);
    go_to(44);   check("t5_lv_rise", bus.lv_out, 1);
    go_to(48);   check("t5_rem48", bus.remaining, 254);
    go_to(1063); check("t5_lv_last", bus.lv_out, 1);
                 check("t5_rem_last", bus.remaining, 1);
    go_to(1064); check("t5_lv_fall", bus.lv_out, 0);
                 check("t5_done", bus.done, 1);
                 check("t5_rem_end", bus.remaining, 0);

    // Start with hold_count=5 while driving a 2-tick level.
    drive(1'b1, 8'd2);
    go_to(1065); drive(1'b0, 8'd0);
    go_to(1068); check("t6_lv_rise", bus.lv_out, 1);
                 check("t6_rem", bus.remaining, 2);
    go_to(1069); drive(1'b1, 8'd5);
    go_to(1070); drive(1'b0, 8'd0);
`ifdef LEVEL_GEN_RETRIGGER_EN
    check("t6_rem_reload", bus.remaining, 5);
    go_to(1076); check("t6_lv1076", bus.lv_out, 1);
                 check("t6_done1076", bus.done, 0);
                 check("t6_rem1076", bus.remaining, 3);
    go_to(1087); check("t6_lv1087", bus.lv_out, 1);
    go_to(1088); check("t6_lv_fall", bus.lv_out, 0);
                 check("t6_done", bus.done, 1);
`else
    check("t6_rem_kept", bus.remaining, 2);
    go_to(1072); check("t6_rem1072", bus.remaining, 1);
    go_to(1076); check("t6_lv_fall", bus.lv_out, 0);
                 check("t6_done", bus.done, 1);
`endif

    // Asynchronous reset mid-DRIVE.
    go_to(1090); drive(1'b1, 8'd3);
    go_to(1091); drive(1'b0, 8'd0);
    go_to(1092); check("t7_lv_rise", bus.lv_out, 1);
    go_to(1094);
    #3 reset_n = 1'b0;
    #1;
    check("t7_lv_rst", bus.lv_out, 0);
    check("t7_busy_rst", bus.busy, 0);
    check("t7_rem_rst", bus.remaining, 0);
    check("t7_done_rst", bus.done, 0);
    @(posedge clk); #1;
    check("t7_done_hold", bus.done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    go_to(1); drive(1'b1, 8'd2);
    go_to(2); drive(1'b0, 8'd0);
    check("t8_busy", bus.busy, 1);
    check("t8_rem", bus.remaining, 2);
    go_to(4);  check("t8_lv_rise", bus.lv_out, 1);
    go_to(8);  check("t8_rem8", bus.remaining, 1);
    go_to(12); check("t8_lv_fall", bus.lv_out, 0);
               check("t8_done", bus.done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
